// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the converter scheduler and display scanner.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [31:0] SEG_DASH  = 32'h40404040;
  localparam logic [31:0] SEG_BLANK = 32'h00000000;

  // Round-robin pick between two level requests; the loser of the last round wins a tie.
  function automatic logic rr_pick(input logic ra, input logic rb, input logic last);
    if (ra && rb) return ~last;
    else if (ra)  return REQ_A;
    else          return REQ_B;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for the 4-digit common-anode display.
module seg_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_reg,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] cnt;
  logic [1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == SCAN_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + SW'(1);
    end
  end

  always_comb begin
    an  = ~(4'b0001 << idx);
    seg = disp_reg[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/seg_conv_sched.sv
// Round-robin scheduler sharing one BCD/seven-segment converter between operand
// entry (A) and ALU result (B), with a WAIT watchdog and a scanned display.
module seg_conv_sched
  import seg_sched_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [13:0] num_a,
  input  logic        err_a,
  input  logic        req_b,
  input  logic [13:0] num_b,
  input  logic        err_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [13:0] conv_num,
  output logic        conv_convert,
  output logic        conv_error,
  input  logic [31:0] conv_digits,
  input  logic        conv_done,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          winner, winner_nx;
  logic          last_served, last_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic [13:0]   num_nx;
  logic          err_nx;
  logic [31:0]   disp_reg, disp_nx;
  logic          terr_nx;

  always_comb begin
    state_nx  = state;
    winner_nx = winner;
    last_nx   = last_served;
    to_cnt_nx = to_cnt;
    num_nx    = conv_num;
    err_nx    = conv_error;
    disp_nx   = disp_reg;
    terr_nx   = timeout_err;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          winner_nx = rr_pick(req_a, req_b, last_served);
          num_nx    = (winner_nx == REQ_A) ? num_a : num_b;
          err_nx    = (winner_nx == REQ_A) ? err_a : err_b;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_nx = '0;
        state_nx  = WAIT;
      end
      WAIT: begin
        // done takes priority over the terminal watchdog count
        if (conv_done) begin
          disp_nx  = conv_digits;
          terr_nx  = 1'b0;
          last_nx  = winner;
          state_nx = IDLE;
        end else if (to_cnt == TO_LAST) begin
          disp_nx  = SEG_DASH;
          terr_nx  = 1'b1;
          last_nx  = winner;
          state_nx = IDLE;
        end else begin
          to_cnt_nx = to_cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are high exactly while in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      winner       <= REQ_B;
      last_served  <= REQ_B;
      to_cnt       <= '0;
      conv_num     <= '0;
      conv_error   <= 1'b0;
      disp_reg     <= SEG_BLANK;
      timeout_err  <= 1'b0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      conv_convert <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      winner       <= winner_nx;
      last_served  <= last_nx;
      to_cnt       <= to_cnt_nx;
      conv_num     <= num_nx;
      conv_error   <= err_nx;
      disp_reg     <= disp_nx;
      timeout_err  <= terr_nx;
      gnt_a        <= (state_nx == ISSUE) && (winner_nx == REQ_A);
      gnt_b        <= (state_nx == ISSUE) && (winner_nx == REQ_B);
      conv_convert <= (state_nx == ISSUE);
      busy         <= (state_nx != IDLE);
    end
  end

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .disp_reg(disp_reg),
    .seg     (seg),
    .an      (an)
  );

endmodule

// File: tb/tb_seg_conv_sched.sv
// Self-checking bench for seg_conv_sched: vector table, randomized transactions
// against a transaction-level model, and hand-written corner sequences.
module tb_seg_conv_sched;

  localparam int SCAN_DIV = 4;
  localparam int TIMEOUT  = 20;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b, err_a, err_b;
  logic [13:0] num_a, num_b;
  logic        gnt_a, gnt_b, conv_convert, conv_error, conv_done;
  logic [13:0] conv_num;
  logic [31:0] conv_digits;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy, timeout_err;

  seg_conv_sched #(
    .SCAN_DIV(SCAN_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a       (req_a),
    .num_a       (num_a),
    .err_a       (err_a),
    .req_b       (req_b),
    .num_b       (num_b),
    .err_b       (err_b),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .conv_num    (conv_num),
    .conv_convert(conv_convert),
    .conv_error  (conv_error),
    .conv_digits (conv_digits),
    .conv_done   (conv_done),
    .seg         (seg),
    .an          (an),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic model_last;

  typedef struct {
    logic        ra, rb;
    logic [13:0] na, nb;
    logic        ea, eb;
    int          dw;        // WAIT cycle (0-based) on which conv_done is driven
    logic [31:0] digits;
    logic        spurious;  // conv_done pulsed during ISSUE (must be ignored)
    logic        exp_b;
    logic [13:0] exp_num;
    logic        exp_err;
    logic [31:0] exp_disp;
    logic        exp_terr;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(input logic ra, input logic rb, input logic [13:0] na,
                              input logic [13:0] nb, input logic ea, input logic eb,
                              input int dw, input logic [31:0] digits, input logic spur,
                              input logic exp_b, input logic [13:0] exp_num,
                              input logic exp_err, input logic [31:0] exp_disp,
                              input logic exp_terr);
    vec_t v;
    v.ra = ra; v.rb = rb; v.na = na; v.nb = nb; v.ea = ea; v.eb = eb;
    v.dw = dw; v.digits = digits; v.spurious = spur;
    v.exp_b = exp_b; v.exp_num = exp_num; v.exp_err = exp_err;
    v.exp_disp = exp_disp; v.exp_terr = exp_terr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_a = 0; req_b = 0; err_a = 0; err_b = 0; num_a = '0; num_b = '0;
    conv_done = 0; conv_digits = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  // Drives one transaction starting in an IDLE cycle and ends in the following IDLE cycle.
  task automatic run_txn(input vec_t v, input string tag);
    logic [13:0] held;
    req_a = v.ra; req_b = v.rb; num_a = v.na; num_b = v.nb; err_a = v.ea; err_b = v.eb;
    conv_digits = v.digits;
    tick;
    chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(!v.exp_b));
    chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(v.exp_b));
    chk({tag, ".convert"}, 32'(conv_convert), 32'd1);
    chk({tag, ".num"}, 32'(conv_num), 32'(v.exp_num));
    chk({tag, ".err"}, 32'(conv_error), 32'(v.exp_err));
    chk({tag, ".busy_issue"}, 32'(busy), 32'd1);
    held = conv_num;
    req_a = 0; req_b = 0; num_a = ~num_a; num_b = ~num_b;
    conv_done = v.spurious;
    tick;
    conv_done = 0;
    for (int w = 0; w < TIMEOUT; w++) begin
      chk({tag, ".wait_strobes"}, {29'd0, conv_convert, gnt_a, gnt_b}, 32'd0);
      chk({tag, ".wait_busy"}, 32'(busy), 32'd1);
      chk({tag, ".wait_num"}, {17'd0, conv_error, conv_num}, {17'd0, v.exp_err, held});
      conv_done = (w == v.dw);
      tick;
      conv_done = 0;
      if (w == v.dw) break;
    end
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".disp"}, dut.disp_reg, v.exp_disp);
    chk({tag, ".terr"}, 32'(timeout_err), 32'(v.exp_terr));
    chk({tag, ".idle_strobes"}, {29'd0, conv_convert, gnt_a, gnt_b}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(1,0,14'd1234,14'd0,0,0, 15,       32'h664F5B06,0, 0,14'd1234,0,32'h664F5B06,0);
    tbl[1] = mk(1,1,14'd5,14'd77,0,0,    3,        32'h12345678,1, 1,14'd77,0,32'h12345678,0);
    tbl[2] = mk(1,1,14'd9,14'd88,1,0,    0,        32'hAABBCCDD,0, 0,14'd9,1,32'hAABBCCDD,0);
    tbl[3] = mk(0,1,14'd0,14'd100,0,1,   5,        32'h763D507C,0, 1,14'd100,1,32'h763D507C,0);
    tbl[4] = mk(1,0,14'd16383,14'd0,0,0, 1000,     32'h0,0,        0,14'd16383,0,32'h40404040,1);
    tbl[5] = mk(0,1,14'd0,14'd3,0,0,     TIMEOUT-1,32'h01020304,1, 1,14'd3,0,32'h01020304,0);
    tbl[6] = mk(1,0,14'd7,14'd0,0,0,     TIMEOUT,  32'h0BADBEEF,0, 0,14'd7,0,32'h40404040,1);
    tbl[7] = mk(1,1,14'd11,14'd22,0,1,   0,        32'h0F0F0F0F,0, 1,14'd22,1,32'h0F0F0F0F,0);

    // Reset state and scanner stepping
    do_reset;
    #1;
    chk("rst.outs", {gnt_a, gnt_b, conv_convert, conv_error, busy, timeout_err}, 32'd0);
    chk("rst.num", 32'(conv_num), 32'd0);
    chk("rst.an", 32'(an), 32'hE);
    chk("rst.seg", 32'(seg), 32'd0);
    repeat (3) tick;
    chk("rst.an_hold", 32'(an), 32'hE);
    tick;
    chk("rst.an_step", 32'(an), 32'hD);

    // Vector table
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Both requests held: A,B,A,B with an IDLE cycle between transactions
    do_reset;
    req_a = 1; req_b = 1; num_a = 14'd1; num_b = 14'd2; conv_digits = 32'h55;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("held%0d.gnt", k), {30'd0, gnt_a, gnt_b},
          (k % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("held%0d.convert", k), 32'(conv_convert), 32'd1);
      for (int w = 0; w < 3; w++) begin
        tick;
        chk($sformatf("held%0d.wait_gnt", k), {30'd0, gnt_a, gnt_b}, 32'd0);
      end
      conv_done = 1;
      tick;
      conv_done = 0;
      chk($sformatf("held%0d.idle", k), {29'd0, busy, gnt_a, gnt_b}, 32'd0);
    end
    req_a = 0; req_b = 0;
    tick;

    // Randomized transactions against the transaction-level model
    do_reset;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      logic ra, rb;
      logic [1:0] r;
      r  = 2'($urandom_range(1, 3));
      ra = r[0]; rb = r[1];
      v.ra = ra; v.rb = rb;
      v.na = 14'($urandom); v.nb = 14'($urandom);
      v.ea = 1'($urandom); v.eb = 1'($urandom);
      v.dw = int'($urandom_range(0, TIMEOUT + 4));
      v.digits = $urandom;
      v.spurious = 1'($urandom);
      v.exp_b = (ra && rb) ? !model_last : rb && !ra;
      v.exp_num = v.exp_b ? v.nb : v.na;
      v.exp_err = v.exp_b ? v.eb : v.ea;
      if (v.dw < TIMEOUT) begin
        v.exp_disp = v.digits; v.exp_terr = 0;
      end else begin
        v.exp_disp = 32'h40404040; v.exp_terr = 1;
      end
      run_txn(v, $sformatf("rnd%0d", n));
      model_last = v.exp_b;
    end

    // Reset in mid-WAIT after a timeout left non-reset state behind
    run_txn(tbl[4], "pre_rst");
    req_a = 1; num_a = 14'd42;
    tick;
    req_a = 0;
    repeat (3) tick;
    rst_n = 0;
    #1;
    chk("midrst.outs", {gnt_a, gnt_b, conv_convert, conv_error, busy, timeout_err}, 32'd0);
    chk("midrst.num", 32'(conv_num), 32'd0);
    chk("midrst.disp", dut.disp_reg, 32'd0);
    chk("midrst.an", 32'(an), 32'hE);
    chk("midrst.seg", 32'(seg), 32'd0);
    @(negedge clk);
    rst_n = 1;
    conv_digits = 32'hDEADBEEF;
    conv_done = 1;
    tick;
    conv_done = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("midrst.late_done", {28'd0, busy, gnt_a, gnt_b, conv_convert}, 32'd0);
      chk("midrst.late_disp", dut.disp_reg, 32'd0);
    end

    // Scanner pattern
    do_reset;
    run_txn(mk(1,0,14'd0,14'd0,0,0,0,32'h11223344,0,0,14'd0,0,32'h11223344,0), "scan_load");
    begin
      logic [3:0]  prev;
      logic [31:0] word;
      bit found;
      found = 0;
      word  = 32'h11223344;
      for (int k = 0; k < 40 && !found; k++) begin
        prev = an;
        tick;
        if (prev != 4'b1110 && an == 4'b1110) found = 1;
      end
      chk("scan.sync", 32'(found), 32'd1);
      for (int c = 0; c < 16; c++) begin
        chk($sformatf("scan%0d.an", c), 32'(an), 32'(~(4'b0001 << (c / 4)) & 4'hF));
        chk($sformatf("scan%0d.seg", c), 32'(seg), 32'(word[8*(c/4) +: 8]));
        tick;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_conv_sched.md
# seg_conv_sched

Scheduler that shares the calculator's single BCD/seven-segment converter between two requesters: operand entry (A) and ALU result (B). It arbitrates requests round-robin, sequences one convert/conv_done transaction at a time with a timeout watchdog, and latches the returned 32-bit segment word. A time-multiplexed scanner drives the 4-digit common-anode display from that word. It sits between the calculator core and the converter/display pins.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles each digit is lit (≥2)
- TIMEOUT, 64, max cycles spent in WAIT before abort (≥20)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req_a  in  1  requester A wants conversion (level)
- num_a  in  14  A value
- err_a  in  1  A error flag
- req_b  in  1  requester B wants conversion (level)
- num_b  in  14  B value
- err_b  in  1  B error flag
- gnt_a  out  1  one-cycle grant to A
- gnt_b  out  1  one-cycle grant to B
- conv_num  out  14  value to converter
- conv_convert  out  1  one-cycle start pulse to converter
- conv_error  out  1  error request to converter
- conv_digits  in  32  segment word from converter, byte k = digit k
- conv_done  in  1  converter completion flag
- seg  out  8  segment bus of the lit digit
- an  out  4  anode enables, active-low, one-hot-low
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  last transaction timed out

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if neither req is high, stay. If one is high, grant it. If both are high, grant the one not served last. last_served resets to B, so A wins first.
- IDLE→ISSUE: capture the winner's num/err into conv_num/conv_error, and record the winner.
- ISSUE (exactly 1 cycle): conv_convert=1 and winner's gnt=1. Go to WAIT and clear the timeout counter.
- WAIT: conv_num/conv_error held stable. The counter increments each cycle.
  - On conv_done=1: latch conv_digits into disp_reg, clear timeout_err, update last_served, go to IDLE.
  - Else, if the counter reaches TIMEOUT-1: load disp_reg with the dash word 32'h40404040, set timeout_err, update last_served, go to IDLE.
  - If conv_done=1 arrives on the terminal count cycle, done wins.
- conv_done is ignored outside WAIT.
- Deassertion of req after grant has no effect on an in-flight transaction.
- A req still high on return to IDLE is a new request and is arbitrated normally.
- conv_convert and both gnt outputs are never high outside ISSUE.
- Scanner:
  - Free-running counter 0..SCAN_DIV-1; on wrap, digit index idx (2 bits) increments, 3→0.
  - an = ~(4'b0001<<idx); seg = disp_reg[8*idx +: 8].
  - disp_reg update takes effect on the next scan cycle without resetting the scan.
- Counter widths: timeout counter $clog2(TIMEOUT); scan counter $clog2(SCAN_DIV); no overflow beyond terminal values.

## Timing
- Reset values (async, rst_n=0):
  - State = IDLE; last_served = B.
  - gnt_a = gnt_b = conv_convert = conv_error = 0; conv_num = 0.
  - disp_reg = 0, so seg = 0 (blank).
  - Scan counter and idx = 0, so an = 4'b1110.
  - busy = 0; timeout_err = 0.
- Reset mid-transaction aborts it; no grant or latch occurs after reset release until a new request arrives.
- Latency: req high in IDLE at cycle 0 → ISSUE/gnt/convert at cycle 1 → WAIT from cycle 2. conv_done seen at cycle n → disp_reg updated at n+1, busy low at n+1. New grant possible at n+2 at the earliest.
- All outputs are registered; no combinational input→output path except seg/an from registered sources.

## Structure
- Package seg_sched_pkg holds:
  - The state enum (IDLE/ISSUE/WAIT).
  - Requester ID constants REQ_A=0, REQ_B=1.
  - Constants SEG_DASH=32'h40404040 and SEG_BLANK=32'h0.
- Sub-module seg_scan holds the scan counter, idx, and the an/seg mux. Its ports are clk, rst_n, disp_reg[31:0], seg, an, and parameter SCAN_DIV.
- seg_conv_sched holds the FSM, arbiter, watchdog, and disp_reg.

## Test plan
- req_a=1, num_a=1234 with a converter model (done after 16 cycles, digits=32'h66_4F_5B_06) → gnt_a at cycle 1, convert pulse one cycle wide, disp_reg=32'h664F5B06, busy low at done+1.
- req_a and req_b both held high for 4 transactions → grant order A,B,A,B; no back-to-back grants closer than the WAIT completion.
- err_b=1 with req_b → conv_error=1 throughout ISSUE/WAIT; the model returns 32'h763D507C, which is latched.
- Converter never asserts conv_done → timeout_err=1 after TIMEOUT cycles in WAIT, disp_reg=32'h40404040, FSM in IDLE. The next successful conversion clears timeout_err.
- rst_n pulsed low in mid-WAIT → all outputs at reset values immediately; a late conv_done after release is ignored and disp_reg stays 0.
- SCAN_DIV=4 with disp_reg=32'h11223344 → an cycles 1110,1101,1011,0111 every 4 cycles with seg 44,33,22,11.
